alu_offset_queue: RTL

Parametrised queue holding the low address bits of ALU results, with access size, for loads and stores whose memory response returns several cycles after the address is issued. It replaces the single two-bit offset register between the ALU-out path and the load/store byte-lane alignment logic. Offset width and queue depth are parameters, and outstanding accesses are tracked in order. Each entry also gets a misalignment check, and overflow and underflow are reported as sticky flags.

---
 rtl/alu_offset_queue.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_offset_queue.sv
// In-order queue of ALU address low bits plus access size for outstanding loads/stores.
// Latency: a push is visible on the head outputs right after its edge; a pop shows the next entry after its edge.
// Backpressure: a push while full is refused unless a pop is accepted in the same cycle.
// A pop while empty is refused. Both refusals raise sticky flags.
module alu_offset_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         offset_in,
    input  logic [1:0]               size_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         offset_out,
    output logic [1:0]               size_out,
    output logic                     misaligned_out,
    output logic                     valid_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic             mis;
        logic [1:0]       size;
        logic [WIDTH-1:0] offset;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf_q;
    logic          unf_q;
    logic          pop_ok;
    logic          push_ok;
    logic          mis_in;

    // Only the two low address bits decide alignment, whatever WIDTH is.
    always_comb begin
        mis_in = 1'b0;
        case (size_in)
            2'd0: mis_in = 1'b0;
            2'd1: mis_in = offset_in[0];
            2'd2: mis_in = (offset_in[1:0] != 2'b00);
            default: mis_in = 1'b1;
        endcase
    end

    // No bypass: a pop needs an entry already held, so push+pop on empty refuses the pop.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= '{mis: mis_in, size: size_in, offset: offset_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (pop && !pop_ok) begin
                unf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        if (cnt == '0) begin
            head = '0;
        end
    end

    assign offset_out     = head.offset;
    assign size_out       = head.size;
    assign misaligned_out = head.mis;
    assign valid_out      = (cnt != '0);
    assign empty          = (cnt == '0);
    assign full           = (cnt == CW'(DEPTH));
    assign count          = cnt;
    assign overflow       = ovf_q;
    assign underflow      = unf_q;

endmodule
